// File: rtl/plic_gateway_if.sv
// plic_gateway_if: bus between the PLIC register block and the gateway/arbiter core
// Signals:
//   src_irq        level interrupt request per source (bit k-1 = source k)
//   claim_*        claim strobe and claimed target, claim_src is the answer
//   complete_*     complete strobe, completed source ID and issuing target
//   cfg_*          per-source priority, per-target enable and threshold
//   int_pending    pending bits (bit 0 always 0)
//   tgt_irq        registered interrupt line per target
// Modports: master = register block side, slave = plic_gateway
interface plic_gateway_if #(
    parameter int SRC_N  = 1,
    parameter int TGT_N  = 1,
    parameter int PRIO_W = 1
);
    logic [SRC_N-1:0]            src_irq;
    logic                        claim_valid;
    logic [4:0]                  claim_tgt;
    logic                        complete_valid;
    logic [4:0]                  complete_src;
    logic [4:0]                  complete_tgt;
    logic [(SRC_N+1)*PRIO_W-1:0] cfg_int_prio;
    logic [TGT_N*(SRC_N+1)-1:0]  cfg_int_enable;
    logic [TGT_N*PRIO_W-1:0]     cfg_threshold;
    logic [SRC_N:0]              int_pending;
    logic [4:0]                  claim_src;
    logic [TGT_N-1:0]            tgt_irq;

    modport master (
        output src_irq, claim_valid, claim_tgt, complete_valid, complete_src, complete_tgt,
        output cfg_int_prio, cfg_int_enable, cfg_threshold,
        input  int_pending, claim_src, tgt_irq
    );

    modport slave (
        input  src_irq, claim_valid, claim_tgt, complete_valid, complete_src, complete_tgt,
        input  cfg_int_prio, cfg_int_enable, cfg_threshold,
        output int_pending, claim_src, tgt_irq
    );
endinterface

// File: rtl/plic_gateway.sv
// plic_gateway: PLIC per-source gateways, pending bits and per-target priority arbitration
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   gw_io  plic_gateway_if.slave: requests, claim/complete strobes, configuration in;
//          int_pending, claim_src (combinational) and tgt_irq (registered) out
module plic_gateway #(
    parameter int SRC_N  = 1,
    parameter int TGT_N  = 1,
    parameter int PRIO_W = 1
) (
    input logic           clk,
    input logic           rst_n,
    plic_gateway_if.slave gw_io
);
    typedef enum logic [1:0] {IDLE, PENDING, CLAIMED} gw_state_e;

    gw_state_e         state_q [1:SRC_N];
    gw_state_e         state_d [1:SRC_N];
    logic [TGT_N-1:0]  tgt_irq_q;
    logic [SRC_N:0]    pend;
    logic [4:0]        arb [TGT_N];
    logic [PRIO_W-1:0] best_p [TGT_N];
    logic [4:0]        claim_src;
    logic [SRC_N:0]    cmp_en;

    always_comb begin
        pend = '0;
        for (int k = 1; k <= SRC_N; k++) pend[k] = state_q[k] == PENDING;
    end

    // The running best starts at the threshold, so only strictly higher priorities
    // qualify (priority 0 never wins); strict > keeps the lowest ID on ties.
    always_comb begin
        for (int t = 0; t < TGT_N; t++) begin
            arb[t]    = '0;
            best_p[t] = gw_io.cfg_threshold[t*PRIO_W +: PRIO_W];
            for (int k = 1; k <= SRC_N; k++) begin
                if (pend[k] && gw_io.cfg_int_enable[t*(SRC_N+1)+k] &&
                    gw_io.cfg_int_prio[k*PRIO_W +: PRIO_W] > best_p[t]) begin
                    best_p[t] = gw_io.cfg_int_prio[k*PRIO_W +: PRIO_W];
                    arb[t]    = 5'(k);
                end
            end
        end
    end

    // Out-of-range target numbers match no t, giving claim_src 0 and no enables.
    always_comb begin
        claim_src = '0;
        cmp_en    = '0;
        for (int t = 0; t < TGT_N; t++) begin
            if (int'(gw_io.claim_tgt) == t) claim_src = arb[t];
            if (int'(gw_io.complete_tgt) == t) cmp_en = gw_io.cfg_int_enable[t*(SRC_N+1) +: SRC_N+1];
        end
    end

    always_comb begin
        for (int k = 1; k <= SRC_N; k++) begin
            state_d[k] = state_q[k];
            unique case (state_q[k])
                IDLE:    if (gw_io.src_irq[k-1]) state_d[k] = PENDING;
                PENDING: if (gw_io.claim_valid && claim_src == 5'(k)) state_d[k] = CLAIMED;
                CLAIMED: if (gw_io.complete_valid && gw_io.complete_src == 5'(k) && cmp_en[k]) state_d[k] = IDLE;
                default: state_d[k] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= '{default: IDLE};
            tgt_irq_q <= '0;
        end else begin
            state_q <= state_d;
            for (int t = 0; t < TGT_N; t++) tgt_irq_q[t] <= arb[t] != '0;
        end
    end

    assign gw_io.int_pending = pend;
    assign gw_io.claim_src   = claim_src;
    assign gw_io.tgt_irq     = tgt_irq_q;
endmodule
